// File: rtl/axi_stream_combiner_2_if.sv
// AXI-stream bundle used by the combiner for both input streams and the merged output.
interface axi_stream #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  tlast;
    logic                  valid;
    logic                  ready;

    modport master (output data, dest, user, tlast, valid, input ready);
    modport slave  (input data, dest, user, tlast, valid, output ready);
endinterface

// File: rtl/axi_stream_combiner_2.sv
// Two-to-one AXI-stream merger with packet-locked arbitration and a single registered output stage.
module axi_stream_combiner_2 #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned DEST_WIDTH    = 8,
    parameter int unsigned USER_WIDTH    = 8,
    parameter int unsigned PACKET_LOCK   = 1,
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic       clock,
    input  logic       reset,
    axi_stream.slave   stream_in_1,
    axi_stream.slave   stream_in_2,
    axi_stream.master  stream_out,
    output logic [1:0] active_source
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_1 = 2'd1,
        LOCK_2 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_is_2;
    logic   last_is_2_next;

    logic [DATA_WIDTH-1:0] out_data;
    logic [DEST_WIDTH-1:0] out_dest;
    logic [USER_WIDTH-1:0] out_user;
    logic                  out_last;
    logic                  out_valid;

    logic space_c;
    logic grant_1_c;
    logic grant_2_c;
    logic ready_1_c;
    logic ready_2_c;
    logic accept_1_c;
    logic accept_2_c;

    // Grant, handshake and next-state decode; state only moves on an accepted beat.
    always_comb begin
        space_c        = ~out_valid | stream_out.ready;
        grant_1_c      = 1'b0;
        grant_2_c      = 1'b0;
        state_next     = state;
        last_is_2_next = last_is_2;

        case (state)
            LOCK_1:  grant_1_c = 1'b1;
            LOCK_2:  grant_2_c = 1'b1;
            default: begin
                if (stream_in_1.valid && stream_in_2.valid) begin
                    if (PRIORITY_MODE != 0 || last_is_2) begin
                        grant_1_c = 1'b1;
                    end else begin
                        grant_2_c = 1'b1;
                    end
                end else begin
                    grant_1_c = stream_in_1.valid;
                    grant_2_c = stream_in_2.valid;
                end
            end
        endcase

        ready_1_c  = grant_1_c & space_c & ~reset;
        ready_2_c  = grant_2_c & space_c & ~reset;
        accept_1_c = stream_in_1.valid & ready_1_c;
        accept_2_c = stream_in_2.valid & ready_2_c;

        if (accept_1_c) begin
            last_is_2_next = 1'b0;
            if (state == IDLE) begin
                state_next = (!stream_in_1.tlast && PACKET_LOCK != 0) ? LOCK_1 : IDLE;
            end else if (stream_in_1.tlast) begin
                state_next = IDLE;
            end
        end else if (accept_2_c) begin
            last_is_2_next = 1'b1;
            if (state == IDLE) begin
                state_next = (!stream_in_2.tlast && PACKET_LOCK != 0) ? LOCK_2 : IDLE;
            end else if (stream_in_2.tlast) begin
                state_next = IDLE;
            end
        end
    end

    // Reset leaves input 2 as last served so input 1 wins the first contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last_is_2 <= 1'b1;
        end else begin
            state     <= state_next;
            last_is_2 <= last_is_2_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dest  <= '0;
            out_user  <= '0;
            out_last  <= 1'b0;
        end else if (accept_1_c) begin
            out_valid <= 1'b1;
            out_data  <= stream_in_1.data;
            out_dest  <= stream_in_1.dest;
            out_user  <= stream_in_1.user;
            out_last  <= stream_in_1.tlast;
        end else if (accept_2_c) begin
            out_valid <= 1'b1;
            out_data  <= stream_in_2.data;
            out_dest  <= stream_in_2.dest;
            out_user  <= stream_in_2.user;
            out_last  <= stream_in_2.tlast;
        end else if (space_c) begin
            out_valid <= 1'b0;
        end
    end

    assign stream_in_1.ready = ready_1_c;
    assign stream_in_2.ready = ready_2_c;

    assign stream_out.valid = out_valid;
    assign stream_out.data  = out_data;
    assign stream_out.dest  = out_dest;
    assign stream_out.user  = out_user;
    assign stream_out.tlast = out_last;

    assign active_source = state;

endmodule

// File: tb/tb_axi_stream_combiner_2.sv
// Directed bench for axi_stream_combiner_2: cycle model plus literal output-sequence checks.
module tb_axi_stream_combiner_2;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          gap;
    } beat_t;

    logic clk = 1'b0;
    logic reset;

    logic [15:0] in_data  [2][2];
    logic [7:0]  in_dest  [2][2];
    logic [7:0]  in_user  [2][2];
    logic        in_last  [2][2];
    logic        in_valid [2][2];
    logic        in_ready [2][2];
    logic        out_ready [2];
    logic [15:0] out_data  [2];
    logic [7:0]  out_dest  [2];
    logic [7:0]  out_user  [2];
    logic        out_last  [2];
    logic        out_valid [2];
    logic [1:0]  active    [2];

    axi_stream #(.DATA_WIDTH(16), .DEST_WIDTH(8), .USER_WIDTH(8))
        a_in1 (), a_in2 (), a_out (), b_in1 (), b_in2 (), b_out ();

    assign a_in1.data = in_data[0][0]; assign a_in1.dest = in_dest[0][0]; assign a_in1.user = in_user[0][0];
    assign a_in1.tlast = in_last[0][0]; assign a_in1.valid = in_valid[0][0]; assign in_ready[0][0] = a_in1.ready;
    assign a_in2.data = in_data[0][1]; assign a_in2.dest = in_dest[0][1]; assign a_in2.user = in_user[0][1];
    assign a_in2.tlast = in_last[0][1]; assign a_in2.valid = in_valid[0][1]; assign in_ready[0][1] = a_in2.ready;
    assign b_in1.data = in_data[1][0]; assign b_in1.dest = in_dest[1][0]; assign b_in1.user = in_user[1][0];
    assign b_in1.tlast = in_last[1][0]; assign b_in1.valid = in_valid[1][0]; assign in_ready[1][0] = b_in1.ready;
    assign b_in2.data = in_data[1][1]; assign b_in2.dest = in_dest[1][1]; assign b_in2.user = in_user[1][1];
    assign b_in2.tlast = in_last[1][1]; assign b_in2.valid = in_valid[1][1]; assign in_ready[1][1] = b_in2.ready;
    assign a_out.ready = out_ready[0]; assign out_data[0] = a_out.data; assign out_dest[0] = a_out.dest;
    assign out_user[0] = a_out.user; assign out_last[0] = a_out.tlast; assign out_valid[0] = a_out.valid;
    assign b_out.ready = out_ready[1]; assign out_data[1] = b_out.data; assign out_dest[1] = b_out.dest;
    assign out_user[1] = b_out.user; assign out_last[1] = b_out.tlast; assign out_valid[1] = b_out.valid;

    axi_stream_combiner_2 dut_a (
        .clock(clk), .reset(reset), .stream_in_1(a_in1), .stream_in_2(a_in2),
        .stream_out(a_out), .active_source(active[0])
    );

    axi_stream_combiner_2 #(.PACKET_LOCK(0), .PRIORITY_MODE(1)) dut_b (
        .clock(clk), .reset(reset), .stream_in_1(b_in1), .stream_in_2(b_in2),
        .stream_out(b_out), .active_source(active[1])
    );

    always #5 clk = ~clk;

    // Instance 0 is packet-locked round robin; instance 1 is per-beat fixed priority.
    int          m_lock [2];
    int          m_prio [2];
    int          m_owner [2];
    int          m_last [2];
    logic        m_valid [2];
    logic [15:0] m_data [2];
    logic [7:0]  m_dest [2];
    logic [7:0]  m_user [2];
    logic        m_tlast [2];
    logic        hold_prev [2];
    logic [15:0] prev_data [2];

    beat_t       q [4][$];
    int          gapcnt [4];
    logic        acc [4];
    logic [15:0] lg [2][$];
    logic [15:0] ex [$];
    logic        pat [4];
    int          checks;
    int          errors;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Spec-level view of one cycle: who may be granted, what the output must show, then advance.
    task automatic model_cycle(input int i);
        logic space;
        int   g;
        logic er [2];
        space = !m_valid[i] || out_ready[i];
        g = 0;
        if (m_owner[i] != 0) g = m_owner[i];
        else if (in_valid[i][0] && in_valid[i][1]) g = (m_prio[i] != 0 || m_last[i] == 2) ? 1 : 2;
        else if (in_valid[i][0]) g = 1;
        else if (in_valid[i][1]) g = 2;
        for (int j = 0; j < 2; j++) begin
            er[j] = (g == j + 1) && space && !reset;
            chk((j == 0) ? "in1_ready" : "in2_ready", i, 32'(in_ready[i][j]), 32'(er[j]));
        end
        chk("out_valid", i, 32'(out_valid[i]), 32'(m_valid[i]));
        chk("active_source", i, 32'(active[i]), 32'(m_owner[i]));
        if (m_valid[i]) begin
            chk("out_data", i, 32'(out_data[i]), 32'(m_data[i]));
            chk("out_dest", i, 32'(out_dest[i]), 32'(m_dest[i]));
            chk("out_user", i, 32'(out_user[i]), 32'(m_user[i]));
            chk("out_last", i, 32'(out_last[i]), 32'(m_tlast[i]));
        end
        if (hold_prev[i]) chk("hold_stable", i, 32'(out_data[i]), 32'(prev_data[i]));
        hold_prev[i] = out_valid[i] && !out_ready[i] && !reset;
        prev_data[i] = out_data[i];
        if (out_valid[i] && out_ready[i] && !reset) lg[i].push_back(out_data[i]);

        if (reset) begin
            m_owner[i] = 0;
            m_last[i]  = 2;
            m_valid[i] = 1'b0;
        end else if (g != 0 && er[g-1] && in_valid[i][g-1]) begin
            m_valid[i] = 1'b1;
            m_data[i]  = in_data[i][g-1];
            m_dest[i]  = in_dest[i][g-1];
            m_user[i]  = in_user[i][g-1];
            m_tlast[i] = in_last[i][g-1];
            m_last[i]  = g;
            if (m_owner[i] == 0) m_owner[i] = (!in_last[i][g-1] && m_lock[i] != 0) ? g : 0;
            else if (in_last[i][g-1]) m_owner[i] = 0;
        end else if (space) begin
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic drive(input int k);
        int i;
        int j;
        i = k / 2;
        j = k % 2;
        if (acc[k] && q[k].size() != 0) begin
            void'(q[k].pop_front());
            gapcnt[k] = 0;
        end
        if (q[k].size() == 0) begin
            in_valid[i][j] = 1'b0;
            in_last[i][j]  = 1'b0;
            gapcnt[k]      = 0;
        end else if (gapcnt[k] < q[k][0].gap) begin
            in_valid[i][j] = 1'b0;
            gapcnt[k]++;
        end else begin
            in_valid[i][j] = 1'b1;
            in_data[i][j]  = q[k][0].data;
            in_dest[i][j]  = q[k][0].data[7:0] ^ 8'h5A;
            in_user[i][j]  = q[k][0].data[15:8] + 8'd1;
            in_last[i][j]  = q[k][0].last;
        end
    endtask

    // One clock: check/advance the model at the falling edge, then drive new inputs just after the rising edge.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) model_cycle(i);
        for (int k = 0; k < 4; k++) acc[k] = in_valid[k/2][k%2] && in_ready[k/2][k%2];
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) drive(k);
    endtask

    task automatic push(input int k, input logic [15:0] d, input logic l, input int g);
        beat_t b;
        b.data = d;
        b.last = l;
        b.gap  = g;
        q[k].push_back(b);
    endtask

    task automatic push_pkt(input int k, input logic [15:0] base, input int n);
        for (int m = 0; m < n; m++) push(k, base + 16'(m), (m == n - 1), 0);
    endtask

    task automatic push_singles(input int k, input logic [15:0] base, input int n);
        for (int m = 0; m < n; m++) push(k, base + 16'(m), 1'b1, 0);
    endtask

    task automatic ex_seq(input logic [15:0] base, input int n);
        for (int m = 0; m < n; m++) ex.push_back(base + 16'(m));
    endtask

    function automatic logic all_idle();
        logic r;
        r = 1'b1;
        for (int k = 0; k < 4; k++) if (q[k].size() != 0 || in_valid[k/2][k%2]) r = 1'b0;
        if (out_valid[0] || out_valid[1]) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (n < limit && !all_idle()) begin
            step();
            n++;
        end
        checks++;
        if (!all_idle()) begin
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", limit);
        end
    endtask

    task automatic chk_log(input int i);
        chk("log_len", i, 32'(lg[i].size()), 32'(ex.size()));
        for (int m = 0; m < ex.size(); m++) begin
            if (m < lg[i].size()) chk("log_beat", i, 32'(lg[i][m]), 32'(ex[m]));
        end
        ex.delete();
        lg[i].delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) q[k].delete();
        step();
        reset = 1'b0;
        lg[0].delete();
        lg[1].delete();
    endtask

    initial begin
        reset  = 1'b1;
        checks = 0;
        errors = 0;
        m_lock = '{1, 0};
        m_prio = '{0, 1};
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = 0; m_last[i] = 2; m_valid[i] = 1'b0;
            m_data[i] = '0; m_dest[i] = '0; m_user[i] = '0; m_tlast[i] = 1'b0;
            hold_prev[i] = 1'b0; prev_data[i] = '0; out_ready[i] = 1'b1;
            for (int j = 0; j < 2; j++) begin
                in_data[i][j] = '0; in_dest[i][j] = '0; in_user[i][j] = '0;
                in_last[i][j] = 1'b0; in_valid[i][j] = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            gapcnt[k] = 0;
            acc[k]    = 1'b0;
        end

        step();
        step();
        reset = 1'b0;
        chk("reset_out_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("reset_out_data", 0, 32'(out_data[0]), 32'd0);
        chk("reset_out_dest", 0, 32'(out_dest[0]), 32'd0);
        chk("reset_out_user", 0, 32'(out_user[0]), 32'd0);
        chk("reset_out_last", 0, 32'(out_last[0]), 32'd0);
        chk("reset_active", 0, 32'(active[0]), 32'd0);
        chk("reset_out_valid", 1, 32'(out_valid[1]), 32'd0);

        // Single 3-beat packet from input 1.
        push_pkt(0, 16'h0011, 3);
        drain(40);
        chk("pkt1_active_after", 0, 32'(active[0]), 32'd0);
        ex_seq(16'h0011, 3);
        chk_log(0);

        // Contention: whole packets, no interleaving, then round robin back to input 1.
        do_reset();
        push_pkt(0, 16'h1000, 4);
        push_pkt(1, 16'h2000, 4);
        drain(60);
        push(0, 16'h1010, 1'b1, 0);
        push(1, 16'h2010, 1'b1, 0);
        drain(40);
        ex_seq(16'h1000, 4);
        ex_seq(16'h2000, 4);
        ex.push_back(16'h1010);
        ex.push_back(16'h2010);
        chk_log(0);

        // Locked input 1 goes quiet for 5 cycles mid-packet; input 2 must wait.
        push(0, 16'h3000, 1'b0, 0);
        push(0, 16'h3001, 1'b0, 0);
        push(0, 16'h3002, 1'b1, 5);
        push(1, 16'h4000, 1'b1, 0);
        drain(60);
        ex_seq(16'h3000, 3);
        ex.push_back(16'h4000);
        chk_log(0);

        // Backpressure pattern 1,0,0,1 during a 6-beat input 2 packet.
        push_pkt(1, 16'h5000, 6);
        for (int c = 0; c < 16; c++) begin
            out_ready[0] = pat[c % 4];
            step();
        end
        out_ready[0] = 1'b1;
        drain(60);
        ex_seq(16'h5000, 6);
        chk_log(0);

        // Fixed priority, per-beat arbitration: input 1 starves input 2 while it stays valid.
        push_singles(2, 16'h6000, 8);
        push_singles(3, 16'h7000, 8);
        drain(80);
        ex_seq(16'h6000, 8);
        ex_seq(16'h7000, 8);
        chk_log(1);

        // Reset in the middle of an input 2 packet.
        push_pkt(1, 16'h8000, 4);
        for (int c = 0; c < 30 && lg[0].size() < 1; c++) step();
        chk("mid_pkt_log", 0, 32'(lg[0].size()), 32'd1);
        chk("mid_pkt_active", 0, 32'(active[0]), 32'd2);
        do_reset();
        chk("post_reset_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("post_reset_active", 0, 32'(active[0]), 32'd0);
        push(0, 16'h9000, 1'b1, 0);
        push(1, 16'h9100, 1'b1, 0);
        drain(40);
        ex.push_back(16'h9000);
        ex.push_back(16'h9100);
        chk_log(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
